ase_latency_scoreboard_ooo: RTL and testbench



---
 rtl/ase_latency_scoreboard_ooo.sv | 168 ++++++++++++++++
 tb/tb_ase_latency_scoreboard_ooo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ase_latency_scoreboard_ooo.sv
// Latency-emulation buffer: holds each request for MIN_LAT (+ optional jitter) cycles,
// then releases it in expiry order tagged with its slot. Jitter enabled by ASE_LATSB_RANDOM_EN.
module ase_latency_scoreboard_ooo #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned HDR_WIDTH     = 64,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned MIN_LAT       = 8,
  parameter int unsigned JITTER_BITS   = 4,
  parameter int unsigned ALMFULL_SLACK = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [HDR_WIDTH-1:0]         hdr_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  output logic [HDR_WIDTH-1:0]         hdr_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH)-1:0]     tag_out,
  output logic                         valid_out,
  input  logic                         read_en,
  output logic                         empty,
  output logic                         almfull,
  output logic                         full,
  output logic                         overflow,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned TAG_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = TAG_W + 1;
  localparam int unsigned MAX_LAT = MIN_LAT + (1 << JITTER_BITS) - 1;
  localparam int unsigned TMR_W   = $clog2(MAX_LAT + 1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 4");
  end
  if (MIN_LAT < 1 || LFSR_SEED == 16'h0) begin : g_bad_cfg
    $error("MIN_LAT must be >= 1 and LFSR_SEED non-zero");
  end

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      queued_q, queued_d;
  logic [TMR_W-1:0]      timer_q [DEPTH];
  logic [TMR_W-1:0]      timer_d [DEPTH];
  logic [HDR_WIDTH-1:0]  hdr_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];

  logic [TAG_W-1:0]      fifo_q  [DEPTH];
  logic [TAG_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  full_c, wr_acc_c, pop_c, exp_vld_c;
  logic [TAG_W-1:0]      free_idx_c, exp_idx_c, head_c;
  logic [JITTER_BITS-1:0] jitter_c;

`ifdef ASE_LATSB_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR x^16+x^14+x^13+x^11+1, stepped once per accepted write
  always_comb begin
    lfsr_d = lfsr_q;
    if (wr_acc_c) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign jitter_c = lfsr_q[JITTER_BITS-1:0];
`else
  assign jitter_c = '0;
`endif

  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign wr_acc_c = valid_in & ~full_c;
  assign head_c   = fifo_q[rd_ptr_q];
  assign pop_c    = valid_out & read_en;

  // Lowest free slot and lowest expired-but-unqueued slot
  always_comb begin
    free_idx_c = '0;
    exp_vld_c  = 1'b0;
    exp_idx_c  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx_c = TAG_W'(i);
      if (valid_q[i] && timer_q[i] == '0 && !queued_q[i]) begin
        exp_vld_c = 1'b1;
        exp_idx_c = TAG_W'(i);
      end
    end
  end

  // Slot and release-queue next state; write, expiry and pop never touch the same slot
  always_comb begin
    valid_d    = valid_q;
    queued_d   = queued_q;
    timer_d    = timer_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(exp_vld_c) - CNT_W'(pop_c);
    count_d    = count_q + CNT_W'(wr_acc_c) - CNT_W'(pop_c);
    overflow_d = overflow_q | (valid_in & full_c);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && timer_q[i] != '0) timer_d[i] = timer_q[i] - TMR_W'(1);
    end
    if (exp_vld_c) begin
      queued_d[exp_idx_c] = 1'b1;
      wr_ptr_d            = wr_ptr_q + TAG_W'(1);
    end
    if (pop_c) begin
      valid_d[head_c]  = 1'b0;
      queued_d[head_c] = 1'b0;
      rd_ptr_d         = rd_ptr_q + TAG_W'(1);
    end
    if (wr_acc_c) begin
      valid_d[free_idx_c]  = 1'b1;
      queued_d[free_idx_c] = 1'b0;
      timer_d[free_idx_c]  = TMR_W'(MIN_LAT) + TMR_W'(jitter_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      queued_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) timer_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      queued_q   <= queued_d;
      timer_q    <= timer_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: outputs are masked by valid_out
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      hdr_q[free_idx_c]  <= hdr_in;
      data_q[free_idx_c] <= data_in;
    end
    if (exp_vld_c) fifo_q[wr_ptr_q] <= exp_idx_c;
  end

  assign valid_out = (fifo_cnt_q != '0);
  assign empty     = ~valid_out;
  assign hdr_out   = valid_out ? hdr_q[head_c]  : '0;
  assign data_out  = valid_out ? data_q[head_c] : '0;
  assign tag_out   = valid_out ? head_c         : '0;
  assign full      = full_c;
  assign almfull   = (count_q >= CNT_W'(DEPTH - ALMFULL_SLACK));
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_ase_latency_scoreboard_ooo.sv
// Self-checking bench for ase_latency_scoreboard_ooo: scoreboard of expected releases plus
// directed corner sequences; the random-jitter scenario builds with ASE_LATSB_RANDOM_EN.
module tb_ase_latency_scoreboard_ooo;

  localparam int unsigned DW = 512;
  localparam int unsigned HW = 64;
  localparam int unsigned DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [HW-1:0]   hdr_in;
  logic [DW-1:0]   data_in;
  logic            valid_in;
  logic [HW-1:0]   hdr_out;
  logic [DW-1:0]   data_out;
  logic [3:0]      tag_out;
  logic            valid_out;
  logic            read_en;
  logic            empty, almfull, full, overflow;
  logic [4:0]      count;

  ase_latency_scoreboard_ooo dut (
    .clk(clk), .rst(rst), .hdr_in(hdr_in), .data_in(data_in), .valid_in(valid_in),
    .hdr_out(hdr_out), .data_out(data_out), .tag_out(tag_out), .valid_out(valid_out),
    .read_en(read_en), .empty(empty), .almfull(almfull), .full(full),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    int            tag;
  } sb_t;

  typedef struct {
    logic          vin;
    logic [HW-1:0] hdr;
    int            exp_count;
    logic          exp_alm;
    logic          exp_full;
    logic          exp_ovf;
  } vec_t;

  sb_t        sb[$];
  bit [15:0]  m_used;
  int         m_cnt;
  bit         m_ovf;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  function automatic logic [DW-1:0] mkdata(input logic [HW-1:0] h);
    return {8{h ^ 64'hA5A5_5A5A_0F0F_F0F0}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; valid_in = 1'b0; read_en = 1'b0; hdr_in = '0; data_in = '0;
    repeat (cycles) tick();
    rst = 1'b0;
    sb.delete();
    m_used = '0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  // One clock: predict write slot, compare popped head, then check status against the model
  task automatic cycle(input logic vin, input logic [HW-1:0] h, input logic ren);
    sb_t e;
    bit  acc, pp;
    int  wslot, pslot;
    pp = ren && valid_out;
    pslot = -1;
    if (pp) begin
      if (sb.size() == 0) begin
        chk("unexpected_release", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("pop_hdr", hdr_out, e.hdr);
        chk("pop_data", data_out, e.data);
        chk("pop_tag", tag_out, e.tag);
        pslot = e.tag;
      end
    end
    acc = vin && (m_cnt != int'(DEPTH));
    wslot = -1;
    if (acc) begin
      for (int i = int'(DEPTH) - 1; i >= 0; i--) if (!m_used[i]) wslot = i;
      e.hdr = h; e.data = mkdata(h); e.tag = wslot;
      sb.push_back(e);
    end
    valid_in = vin; hdr_in = h; data_in = mkdata(h); read_en = ren;
    tick();
    valid_in = 1'b0; read_en = 1'b0;
    if (vin && !acc) m_ovf = 1'b1;
    if (pslot >= 0) m_used[pslot] = 1'b0;
    if (wslot >= 0) m_used[wslot] = 1'b1;
    m_cnt = m_cnt + int'(acc) - int'(pp);
    chk("count", count, m_cnt);
    chk("full", full, m_cnt == int'(DEPTH));
    chk("almfull", almfull, m_cnt >= 12);
    chk("overflow", overflow, m_ovf);
    chk("empty", empty, !valid_out);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!valid_out && n < limit) begin
      cycle(1'b0, '0, 1'b0);
      n++;
    end
    chk("wait_valid_timeout", valid_out, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && sb.size() > 0; n++) cycle(1'b0, '0, 1'b1);
    chk(name, sb.size(), 0);
  endtask

`ifdef ASE_LATSB_RANDOM_EN
  initial begin
    int        wtime [64];
    bit        seen  [64];
    int        next_h, got, last_h, h;
    bit        ooo;
    do_reset(2);
    next_h = 0; got = 0; last_h = -1; ooo = 1'b0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int n = 0; n < 3000 && got < 64; n++) begin
      if (valid_out) begin
        h = int'(hdr_out[5:0]);
        chk("r_hdr_range", hdr_out[63:6], '0);
        chk("r_data", data_out, mkdata(hdr_out));
        chk("r_dup", seen[h], 1'b0);
        chk("r_latency_ge9", (cyc - wtime[h]) >= 9, 1'b1);
        seen[h] = 1'b1;
        if (h < last_h) ooo = 1'b1;
        last_h = h;
        got++;
      end
      read_en = 1'b1;
      valid_in = (next_h < 64) && !full;
      hdr_in = HW'(next_h);
      data_in = mkdata(HW'(next_h));
      tick();
      if (valid_in) begin
        wtime[next_h] = cyc;
        next_h++;
      end
      valid_in = 1'b0;
    end
    chk("r_all_returned", got, 64);
    chk("r_out_of_order", ooo, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
`else
  initial begin
    vec_t fill [17];
    int   n;
    logic [HW-1:0] h0;
    logic [3:0]    t0;

    // Fill table: 17 back-to-back writes into an empty buffer, last one dropped
    for (int k = 0; k < 17; k++) begin
      fill[k].vin       = 1'b1;
      fill[k].hdr       = HW'(k);
      fill[k].exp_count = (k < 16) ? k + 1 : 16;
      fill[k].exp_alm   = fill[k].exp_count >= 12;
      fill[k].exp_full  = fill[k].exp_count == 16;
      fill[k].exp_ovf   = (k == 16);
    end

    // Reset state
    do_reset(2);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_almfull", almfull, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_hdr_out", hdr_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_tag_out", tag_out, 0);

    // Single write latency
    cycle(1'b1, 64'h1, 1'b0);
    wait_valid(50, n);
    chk("t1_latency", n, 9);
    chk("t1_tag", tag_out, 0);
    chk("t1_hdr", hdr_out, 64'h1);
    cycle(1'b0, '0, 1'b1);
    chk("t1_empty", empty, 1'b1);
    chk("t1_count", count, 0);

    // Fill to full, overflow, drain in order
    for (int k = 0; k < 17; k++) begin
      cycle(fill[k].vin, fill[k].hdr, 1'b0);
      chk("t2_count", count, fill[k].exp_count);
      chk("t2_almfull", almfull, fill[k].exp_alm);
      chk("t2_full", full, fill[k].exp_full);
      chk("t2_overflow", overflow, fill[k].exp_ovf);
    end
    drain("t2_drained");
    chk("t2_overflow_sticky", overflow, 1'b1);
    chk("t2_count_zero", count, 0);

    // Write at full with simultaneous pop is dropped
    do_reset(1);
    for (int k = 0; k < 16; k++) cycle(1'b1, HW'(100 + k), 1'b0);
    wait_valid(50, n);
    cycle(1'b1, 64'hBAD, 1'b1);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_count", count, 15);
    drain("t3_drained");

    // Held head is stable, then back-to-back pops
    do_reset(1);
    for (int k = 0; k < 4; k++) cycle(1'b1, HW'(200 + k), 1'b0);
    wait_valid(50, n);
    h0 = hdr_out; t0 = tag_out;
    chk("t4_first_hdr", h0, 200);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, 1'b0);
      chk("t4_hdr_stable", hdr_out, h0);
      chk("t4_tag_stable", tag_out, t0);
    end
    for (int k = 0; k < 4; k++) begin
      chk("t4_valid_consec", valid_out, 1'b1);
      cycle(1'b0, '0, 1'b1);
    end
    chk("t4_empty", empty, 1'b1);
    chk("t4_sb_empty", sb.size(), 0);

    // Reset with entries in flight discards them
    do_reset(1);
    for (int k = 0; k < 5; k++) cycle(1'b1, HW'(300 + k), 1'b0);
    do_reset(1);
    chk("t5_count", count, 0);
    chk("t5_valid_out", valid_out, 1'b0);
    chk("t5_overflow", overflow, 1'b0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b0, '0, 1'b1);
      if (valid_out) n++;
    end
    chk("t5_no_stale_release", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
`endif

endmodule
